// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter: measures the period and high time of an asynchronous
// monitored clock in clk_in cycles. For each clk_mon period it reports
// whether the duty cycle is 50 % within one-cycle quantisation and whether
// the period matches the programmed divider ratio. A stuck or missing
// clk_mon raises a sticky timeout flag.
module clk_ratio_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 65535
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clk_mon,
    input  logic [CNT_W-1:0] expected,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             duty_ok,
    output logic             ratio_ok,
    output logic             timeout
);

    localparam logic [1:0] SEEK       = 2'd0;
    localparam logic [1:0] MEASURE_HI = 2'd1;
    localparam logic [1:0] MEASURE_LO = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // The counter reaches TIMEOUT on the increment that follows this value.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic signed [CNT_W+1:0] DIFF_ONE = (CNT_W+2)'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   mon_s;
    logic                   mon_d;
    logic                   rise;
    logic                   fall;

    logic [1:0]             state, state_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx, cnt_inc;
    logic [CNT_W-1:0]       hi_cap, hi_cap_nx;
    logic                   result_ld;
    logic                   timeout_hit;

    logic signed [CNT_W+1:0] duty_diff;
    logic                    duty_nx;
    logic                    ratio_nx;

    assign mon_s = sync_q[SYNC_STAGES-1];
    assign rise  =  mon_s & ~mon_d;
    assign fall  = ~mon_s &  mon_d;

    // Synchronise clk_mon into the clk_in domain and keep one delayed copy
    // for edge detection; both edges see the same latency.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            mon_d  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, so the shift register really has SYNC_STAGES
            // stages instead of collapsing into one.
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_mon};
            mon_d  <= mon_s;
        end
    end

    // Next-state, counter and capture decisions for the measurement FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_nx    = state;
        cnt_nx      = cnt;
        hi_cap_nx   = hi_cap;
        result_ld   = 1'b0;
        timeout_hit = 1'b0;
        cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

        if (!en) begin
            state_nx = SEEK;
            cnt_nx   = '0;
        end else begin
            case (state)
                SEEK: begin
                    cnt_nx = '0;
                    if (rise) begin
                        state_nx = MEASURE_HI;
                        cnt_nx   = CNT_ONE;
                    end
                end
                MEASURE_HI: begin
                    if (fall) begin
                        hi_cap_nx = cnt;
                        state_nx  = MEASURE_LO;
                        cnt_nx    = cnt_inc;
                    end else if (cnt == TO_LAST) begin
                        timeout_hit = 1'b1;
                        state_nx    = SEEK;
                        cnt_nx      = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                MEASURE_LO: begin
                    if (rise) begin
                        result_ld = 1'b1;
                        state_nx  = MEASURE_HI;
                        cnt_nx    = CNT_ONE;
                    end else if (cnt == TO_LAST) begin
                        timeout_hit = 1'b1;
                        state_nx    = SEEK;
                        cnt_nx      = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                default: begin
                    state_nx = SEEK;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Duty and ratio verdicts for the period that completes this cycle;
    // the extra two bits keep 2*high_time - period from overflowing.
    always_comb begin
        duty_diff = $signed({1'b0, hi_cap, 1'b0}) - $signed({2'b00, cnt});
        duty_nx   = (duty_diff >= -DIFF_ONE) && (duty_diff <= DIFF_ONE);
        ratio_nx  = (cnt == expected);
    end

    // FSM state, running counter and captured high time.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state  <= SEEK;
            cnt    <= '0;
            hi_cap <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            hi_cap <= hi_cap_nx;
        end
    end

    // Result registers: updated only on a completed period, held otherwise.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            duty_ok    <= 1'b0;
            ratio_ok   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= result_ld;
            if (result_ld) begin
                period    <= cnt;
                high_time <= hi_cap;
                duty_ok   <= duty_nx;
                ratio_ok  <= ratio_nx;
                timeout   <= 1'b0;
            end else if (timeout_hit) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// tb_clk_ratio_meter: table-driven periods with a result scoreboard, plus
// hand-written enable, stuck-clock, reset and asynchronous-clock sequences.
module tb_clk_ratio_meter;

    localparam int CNT_W = 16;

    logic             clk_in    = 1'b0;
    logic             rst_n     = 1'b0;
    logic             en        = 1'b0;
    logic             mon_sync  = 1'b0;
    logic             clk_async = 1'b0;
    logic             async_sel = 1'b0;
    logic             clk_mon;
    logic [CNT_W-1:0] expected  = '0;

    logic             meas_valid;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             duty_ok;
    logic             ratio_ok;
    logic             timeout;

    typedef struct {
        logic [15:0] p_lo, p_hi, h_lo, h_hi;
        logic        duty, ratio, chk_ratio;
    } exp_t;

    typedef struct {
        int          hi, lo, n;
        logic [15:0] exp_in, period, high;
        logic        duty, ratio;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[7];

    int   n_checks    = 0;
    int   n_pass      = 0;
    int   x_seen      = 0;
    logic async_count = 1'b0;
    logic async_first = 1'b0;

    assign clk_mon = async_sel ? clk_async : mon_sync;

    clk_ratio_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2),
        .TIMEOUT     (20)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .en         (en),
        .clk_mon    (clk_mon),
        .expected   (expected),
        .meas_valid (meas_valid),
        .period     (period),
        .high_time  (high_time),
        .duty_ok    (duty_ok),
        .ratio_ok   (ratio_ok),
        .timeout    (timeout)
    );

    always #50 clk_in = ~clk_in;

    // Unrelated clock: 1428-unit period against 100 for clk_in (~14.28 cycles).
    initial begin
        #17;
        forever #714 clk_async = ~clk_async;
    end

    task automatic check(input logic ok, input string name, input longint act, input longint req);
        n_checks++;
        if (ok === 1'b1) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic push_exact(input int n, input logic [15:0] p, input logic [15:0] h,
                              input logic d, input logic r);
        exp_t e;
        e.p_lo = p; e.p_hi = p; e.h_lo = h; e.h_hi = h;
        e.duty = d; e.ratio = r; e.chk_ratio = 1'b1;
        repeat (n) sb_q.push_back(e);
    endtask

    // Called on a falling clk_in edge; holds clk_mon at v for n cycles.
    task automatic drive_level(input logic v, input int n);
        mon_sync = v;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic check_drained(input string name);
        check(sb_q.size() == 0, name, sb_q.size(), 0);
        sb_q.delete();
    endtask

    // n full periods plus a trailing rise give exactly n results.
    task automatic run_vec(input vec_t v);
        expected = v.exp_in;
        push_exact(v.n, v.period, v.high, v.duty, v.ratio);
        en = 1'b1;
        drive_level(1'b0, 2);
        repeat (v.n + 1) begin
            drive_level(1'b1, v.hi);
            drive_level(1'b0, v.lo);
        end
        drive_level(1'b0, 4);
        en = 1'b0;
        drive_level(1'b0, 4);
        check_drained("vec_drained");
    endtask

    // Each async rise after the first one seen while enabled closes a period.
    always @(posedge clk_async) begin
        if (async_count) begin
            if (async_first) begin
                async_first = 1'b0;
            end else begin
                exp_t e;
                e.p_lo = 16'd14; e.p_hi = 16'd15; e.h_lo = 16'd7; e.h_hi = 16'd8;
                e.duty = 1'b1; e.ratio = 1'b0; e.chk_ratio = 1'b0;
                sb_q.push_back(e);
            end
        end
    end

    // Scoreboard consumer, sampling just after each rising clk_in edge.
    always @(posedge clk_in) begin
        #1;
        if ($isunknown({meas_valid, period, high_time, duty_ok, ratio_ok, timeout})) x_seen++;
        if (meas_valid === 1'b1) begin
            check(sb_q.size() != 0, "unexpected_meas_valid", 1, 0);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check(period >= mon_e.p_lo && period <= mon_e.p_hi, "period", period, mon_e.p_lo);
                check(high_time >= mon_e.h_lo && high_time <= mon_e.h_hi, "high_time", high_time, mon_e.h_lo);
                check(duty_ok == mon_e.duty, "duty_ok", duty_ok, mon_e.duty);
                if (mon_e.chk_ratio) check(ratio_ok == mon_e.ratio, "ratio_ok", ratio_ok, mon_e.ratio);
                check(timeout == 1'b0, "timeout_on_valid", timeout, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got 0, required 1");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3, 2, 4, 16'd5,  16'd5,  16'd3, 1'b1, 1'b1};
        vecs[1] = '{2, 2, 3, 16'd5,  16'd4,  16'd2, 1'b1, 1'b0};
        vecs[2] = '{1, 7, 3, 16'd8,  16'd8,  16'd1, 1'b0, 1'b1};
        vecs[3] = '{2, 3, 2, 16'd5,  16'd5,  16'd2, 1'b1, 1'b1};
        vecs[4] = '{1, 1, 3, 16'd2,  16'd2,  16'd1, 1'b1, 1'b1};
        vecs[5] = '{4, 6, 2, 16'd10, 16'd10, 16'd4, 1'b0, 1'b1};
        vecs[6] = '{6, 6, 2, 16'd12, 16'd12, 16'd6, 1'b1, 1'b1};

        // Reset values.
        repeat (3) @(negedge clk_in);
        check(meas_valid == 1'b0, "rst_meas_valid", meas_valid, 0);
        check(period == '0, "rst_period", period, 0);
        check(high_time == '0, "rst_high_time", high_time, 0);
        check(duty_ok == 1'b0, "rst_duty_ok", duty_ok, 0);
        check(ratio_ok == 1'b0, "rst_ratio_ok", ratio_ok, 0);
        check(timeout == 1'b0, "rst_timeout", timeout, 0);
        rst_n = 1'b1;
        drive_level(1'b0, 2);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Enable dropped for 3 cycles inside a period: that period and the
        // partial one after re-enable are never reported.
        expected = 16'd8;
        push_exact(3, 16'd8, 16'd4, 1'b1, 1'b1);
        en = 1'b1;
        drive_level(1'b0, 2);
        repeat (2) begin
            drive_level(1'b1, 4);
            drive_level(1'b0, 4);
        end
        drive_level(1'b1, 4);
        en = 1'b0;
        drive_level(1'b0, 3);
        en = 1'b1;
        drive_level(1'b0, 1);
        repeat (2) begin
            drive_level(1'b1, 4);
            drive_level(1'b0, 4);
        end
        en = 1'b0;
        drive_level(1'b0, 4);
        check_drained("en_drop_drained");

        // Stuck-high clk_mon: timeout 20 cycles after the last detected rise.
        expected = 16'd5;
        push_exact(3, 16'd5, 16'd3, 1'b1, 1'b1);
        en = 1'b1;
        drive_level(1'b0, 2);
        repeat (3) begin
            drive_level(1'b1, 3);
            drive_level(1'b0, 2);
        end
        mon_sync = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk_in);
            #1;
            if (k == 21) check(timeout == 1'b0, "timeout_early", timeout, 0);
            if (k == 22) check(timeout == 1'b1, "timeout_at_20", timeout, 1);
        end
        @(negedge clk_in);
        check(timeout == 1'b1, "timeout_sticky", timeout, 1);
        check(period == 16'd5, "hold_period", period, 5);
        check(high_time == 16'd3, "hold_high_time", high_time, 3);
        check(duty_ok == 1'b1 && ratio_ok == 1'b1, "hold_flags", {duty_ok, ratio_ok}, 3);
        check_drained("stuck_drained");
        push_exact(1, 16'd5, 16'd3, 1'b1, 1'b1);
        drive_level(1'b0, 3);
        drive_level(1'b1, 3);
        drive_level(1'b0, 2);
        drive_level(1'b1, 3);
        drive_level(1'b0, 4);
        check(timeout == 1'b0, "timeout_cleared", timeout, 0);
        en = 1'b0;
        drive_level(1'b0, 4);
        check_drained("resume_drained");

        // Reset in MEASURE_LO: outputs clear at once, no result for that period.
        push_exact(2, 16'd5, 16'd3, 1'b1, 1'b1);
        en = 1'b1;
        drive_level(1'b0, 2);
        repeat (2) begin
            drive_level(1'b1, 3);
            drive_level(1'b0, 2);
        end
        drive_level(1'b1, 3);
        drive_level(1'b0, 3);
        rst_n = 1'b0;
        #1;
        check(meas_valid == 1'b0, "mid_rst_meas_valid", meas_valid, 0);
        check(period == '0, "mid_rst_period", period, 0);
        check(high_time == '0, "mid_rst_high_time", high_time, 0);
        check(duty_ok == 1'b0 && ratio_ok == 1'b0, "mid_rst_flags", {duty_ok, ratio_ok}, 0);
        @(negedge clk_in);
        rst_n = 1'b1;
        push_exact(1, 16'd5, 16'd3, 1'b1, 1'b1);
        drive_level(1'b0, 2);
        drive_level(1'b1, 3);
        drive_level(1'b0, 2);
        drive_level(1'b1, 3);
        drive_level(1'b0, 4);
        en = 1'b0;
        drive_level(1'b0, 4);
        check_drained("reset_drained");

        // Asynchronous clk_mon at ~14.28 clk_in cycles per period.
        expected  = 16'd14;
        async_sel = 1'b1;
        @(negedge clk_async);
        repeat (3) @(negedge clk_in);
        en          = 1'b1;
        async_first = 1'b1;
        async_count = 1'b1;
        repeat (10) @(posedge clk_async);
        @(negedge clk_async);
        async_count = 1'b0;
        repeat (5) @(negedge clk_in);
        en = 1'b0;
        repeat (4) @(negedge clk_in);
        check_drained("async_drained");
        async_sel = 1'b0;
        drive_level(1'b0, 2);

        check(x_seen == 0, "no_x_outputs", x_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
